// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU layer sequencer.
//   state_t      : sequencer FSM encoding
//   NUM_OUT_BUSY : all-ones pattern reported on num_out while no valid result exists
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LRST = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Truncated to the class-index width at the point of use.
  localparam logic [31:0] NUM_OUT_BUSY = '1;

endpackage

// File: rtl/tpu_layer_mux.sv
// N-way slice selector for per-layer buses; drives zero when no layer owns the bus.
// Ports:
//   din   : N*W flattened inputs, slice k at [k*W +: W]
//   sel   : slice index
//   valid : 1 = pass selected slice, 0 = output zero
//   dout  : selected slice (combinational)
module tpu_layer_mux #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] din,
  input  logic [SEL_W-1:0] sel,
  input  logic           valid,
  output logic [W-1:0]   dout
);

  // Out-of-range indices also read as zero rather than X.
  always_comb begin
    dout = '0;
    if (valid && (32'(sel) < N)) begin
      dout = din[sel*W +: W];
    end
  end

endmodule

// File: rtl/tpu_layer_sequencer.sv
// Runs NUM_LAYERS layer engines back to back: each gets a one-cycle local reset,
// then exclusive use of the shared weight ROM and MultAdder until it reports done.
// Ports:
//   clk, iRst_n (sync, active-low), ena (0 = freeze), start, abort
//   layer_done/layer_ovf/layer_rom_addr/layer_opr1/layer_opr2 : per-layer inputs
//   class_idx : argmax of the final layer
//   layer_ena/layer_rstn : per-layer enable and local reset
//   rom_addr/opr1/opr2   : shared buses, muxed from the active layer (combinational)
//   num_out/overflow/timeout/busy/done : run status and result
module tpu_layer_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned OPR_W       = 1024,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         iRst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_LAYERS-1:0]        layer_done,
  input  logic [NUM_LAYERS-1:0]        layer_ovf,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_rom_addr,
  input  logic [NUM_LAYERS*OPR_W-1:0]  layer_opr1,
  input  logic [NUM_LAYERS*OPR_W-1:0]  layer_opr2,
  input  logic [IDX_W-1:0]             class_idx,
  output logic [NUM_LAYERS-1:0]        layer_ena,
  output logic [NUM_LAYERS-1:0]        layer_rstn,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [OPR_W-1:0]             opr1,
  output logic [OPR_W-1:0]             opr2,
  output logic [IDX_W-1:0]             num_out,
  output logic                         overflow,
  output logic                         timeout,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CUR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] BUSY_VAL = IDX_W'(NUM_OUT_BUSY);

  state_t                state_q, state_d;
  logic [CUR_W-1:0]      cur_q, cur_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NUM_LAYERS-1:0] layer_ena_q, layer_ena_d;
  logic [NUM_LAYERS-1:0] layer_rstn_q, layer_rstn_d;
  logic [IDX_W-1:0]      num_out_q, num_out_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bus_valid;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      wd_q         <= '0;
      layer_ena_q  <= '0;
      layer_rstn_q <= '1;
      num_out_q    <= BUSY_VAL;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      wd_q         <= wd_d;
      layer_ena_q  <= layer_ena_d;
      layer_rstn_q <= layer_rstn_d;
      num_out_q    <= num_out_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    wd_d         = wd_q;
    layer_ena_d  = layer_ena_q;
    layer_rstn_d = '1;          // local reset is a single-cycle pulse
    num_out_d    = num_out_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    done_d       = done_q;

    if (!ena) begin
      layer_rstn_d = layer_rstn_q;
    end else if (abort) begin
      state_d     = IDLE;
      cur_d       = '0;
      wd_d        = '0;
      layer_ena_d = '0;
      num_out_d   = BUSY_VAL;
      overflow_d  = 1'b0;
      timeout_d   = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d         = LRST;
            cur_d           = '0;
            layer_ena_d     = '0;
            layer_ena_d[0]  = 1'b1;
            layer_rstn_d[0] = 1'b0;
            num_out_d       = BUSY_VAL;
            overflow_d      = 1'b0;
            timeout_d       = 1'b0;
            done_d          = 1'b0;
          end
        end
        LRST: begin
          state_d = RUN;
          wd_d    = '0;
        end
        RUN: begin
          wd_d = wd_q + WD_W'(1);
          // Layer completion takes precedence over a same-cycle watchdog expiry.
          if (layer_done[cur_q]) begin
            overflow_d  = overflow_q | layer_ovf[cur_q];
            layer_ena_d = '0;
            if (cur_q == CUR_W'(NUM_LAYERS - 1)) begin
              state_d   = DONE;
              num_out_d = class_idx;
              done_d    = 1'b1;
            end else begin
              // Hand over to the next layer on the same edge.
              cur_d               = cur_q + CUR_W'(1);
              state_d             = LRST;
              layer_ena_d[cur_d]  = 1'b1;
              layer_rstn_d[cur_d] = 1'b0;
            end
          end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d     = DONE;
            layer_ena_d = '0;
            num_out_d   = BUSY_VAL;
            timeout_d   = 1'b1;
            done_d      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LRST) || (state_d == RUN);
  end

  assign layer_ena  = layer_ena_q;
  assign layer_rstn = layer_rstn_q;
  assign num_out    = num_out_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // The active layer owns the shared buses only while it is in LRST or RUN.
  assign bus_valid = (state_q == LRST) || (state_q == RUN);

  tpu_layer_mux #(.N(NUM_LAYERS), .W(ADDR_W), .SEL_W(CUR_W)) u_mux_rom (
    .din   (layer_rom_addr),
    .sel   (cur_q),
    .valid (bus_valid),
    .dout  (rom_addr)
  );

  tpu_layer_mux #(.N(NUM_LAYERS), .W(OPR_W), .SEL_W(CUR_W)) u_mux_opr1 (
    .din   (layer_opr1),
    .sel   (cur_q),
    .valid (bus_valid),
    .dout  (opr1)
  );

  tpu_layer_mux #(.N(NUM_LAYERS), .W(OPR_W), .SEL_W(CUR_W)) u_mux_opr2 (
    .din   (layer_opr2),
    .sel   (cur_q),
    .valid (bus_valid),
    .dout  (opr2)
  );

endmodule
